// File: rtl/scrambler_par_if.sv
// Stream and control bundle for scrambler_par: input beat stream, output beat stream,
// per-frame seed/mode and the lock indication.
interface scrambler_par_if #(
    parameter int W   = 1,
    parameter int LEN = 7
);
    logic           Mode;
    logic [LEN-1:0] Seed;
    logic [W-1:0]   In_Data;
    logic [W-1:0]   In_Tail;
    logic           In_Sop;
    logic           In_Valid;
    logic           In_Ready;
    logic [W-1:0]   Out_Data;
    logic           Out_Sop;
    logic           Out_Valid;
    logic           Out_Ready;
    logic           Locked;

    modport slave (
        input  Mode, Seed, In_Data, In_Tail, In_Sop, In_Valid, Out_Ready,
        output In_Ready, Out_Data, Out_Sop, Out_Valid, Locked
    );

    modport master (
        output Mode, Seed, In_Data, In_Tail, In_Sop, In_Valid, Out_Ready,
        input  In_Ready, Out_Data, Out_Sop, Out_Valid, Locked
    );
endinterface

// File: rtl/scrambler_par.sv
// W-bit-per-beat additive LFSR (x^LEN + x^TAP + 1) scrambler/descrambler with
// per-frame seeding, tail masking and receive-side seed recovery.
module scrambler_par #(
    parameter int W   = 1,
    parameter int LEN = 7,
    parameter int TAP = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    scrambler_par_if.slave    io_bus
);
    localparam int RCW = $clog2(LEN + 1);
    localparam logic [RCW-1:0] RC_FULL = RCW'(LEN);

    logic [LEN-1:0] r_state;
    logic [RCW-1:0] r_rc;
    logic           r_mode;
    logic           r_locked;
    logic           r_out_valid;
    logic [W-1:0]   r_out_data;
    logic           r_out_sop;

    logic           w_in_ready;
    logic           w_accept;
    logic           w_mode;
    logic [LEN-1:0] w_seed_state;
    logic [LEN-1:0] w_st [0:W];
    logic [RCW-1:0] w_rc [0:W];
    logic [W-1:0]   w_out;
    logic           w_locked_next;

    assign w_in_ready = !r_out_valid || io_bus.Out_Ready;
    assign w_accept   = io_bus.In_Valid && w_in_ready;

    // Mode and starting state come from the port on an SOP beat, else from the frame context.
    assign w_mode       = io_bus.In_Sop ? io_bus.Mode : r_mode;
    assign w_seed_state = (io_bus.Seed == '0) ? '1 : io_bus.Seed;
    assign w_st[0]      = (io_bus.In_Sop && !io_bus.Mode) ? w_seed_state : r_state;
    assign w_rc[0]      = io_bus.In_Sop ? (io_bus.Mode ? '0 : RC_FULL) : r_rc;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            logic w_rec;
            logic w_fb;
            // While recovering, the received bit itself becomes the new x_1 and output is muted.
            assign w_rec = w_mode && (w_rc[gi] < RC_FULL);
            assign w_fb  = w_st[gi][LEN-1] ^ w_st[gi][TAP-1];
            assign w_st[gi+1] = {w_st[gi][LEN-2:0], (w_rec ? io_bus.In_Data[gi] : w_fb)};
            assign w_rc[gi+1] = w_rec ? (w_rc[gi] + 1'b1) : w_rc[gi];
            assign w_out[gi]  = (w_rec ? 1'b0 : (io_bus.In_Data[gi] ^ w_fb)) & ~io_bus.In_Tail[gi];
        end
    endgenerate

    assign w_locked_next = w_mode ? (w_rc[W] == RC_FULL) : (io_bus.In_Sop || r_locked);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= '1;
            r_rc        <= RC_FULL;
            r_mode      <= 1'b0;
            r_locked    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
        end else if (w_accept) begin
            r_state     <= w_st[W];
            r_rc        <= w_rc[W];
            r_mode      <= w_mode;
            r_locked    <= w_locked_next;
            r_out_valid <= 1'b1;
            r_out_data  <= w_out;
            r_out_sop   <= io_bus.In_Sop;
        end else if (io_bus.Out_Ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign io_bus.In_Ready  = w_in_ready;
    assign io_bus.Out_Data  = r_out_data;
    assign io_bus.Out_Sop   = r_out_sop;
    assign io_bus.Out_Valid = r_out_valid;
    assign io_bus.Locked    = r_locked;
endmodule

// File: tb/tb_scrambler_par.sv
// Directed checks of scrambler_par at W=8 and W=1 against the 802.11a all-ones
// keystream 0x70 0x4F 0x93 0x40 0x64 0x74 (bit 0 first).
module tb_scrambler_par;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    scrambler_par_if #(.W(8), .LEN(7)) bus8 ();
    scrambler_par_if #(.W(1), .LEN(7)) bus1 ();

    scrambler_par #(.W(8), .LEN(7), .TAP(4)) u_dut8 (
        .Clk    (clk),
        .Reset  (rst),
        .io_bus (bus8.slave)
    );

    scrambler_par #(.W(1), .LEN(7), .TAP(4)) u_dut1 (
        .Clk    (clk),
        .Reset  (rst),
        .io_bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic beat8(input logic [7:0] d, input logic [7:0] t, input logic sop);
        bus8.In_Data  = d;
        bus8.In_Tail  = t;
        bus8.In_Sop   = sop;
        bus8.In_Valid = 1'b1;
        @(posedge clk);
        #1;
        bus8.In_Valid = 1'b0;
        bus8.In_Sop   = 1'b0;
        bus8.In_Tail  = '0;
    endtask

    task automatic bit1(input logic d, input logic sop);
        bus1.In_Data  = d;
        bus1.In_Sop   = sop;
        bus1.In_Valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.In_Valid = 1'b0;
        bus1.In_Sop   = 1'b0;
    endtask

    initial begin
        logic [15:0] ks;
        total = 0;
        bad   = 0;
        ks    = 16'h4F70;
        rst   = 1'b1;
        bus8.Mode = 1'b0; bus8.Seed = 7'h7F; bus8.In_Data = '0; bus8.In_Tail = '0;
        bus8.In_Sop = 1'b0; bus8.In_Valid = 1'b0; bus8.Out_Ready = 1'b1;
        bus1.Mode = 1'b0; bus1.Seed = 7'h7F; bus1.In_Data = '0; bus1.In_Tail = '0;
        bus1.In_Sop = 1'b0; bus1.In_Valid = 1'b0; bus1.Out_Ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus8.Out_Valid), 32'd0);
        chk("rst_out_data",  32'(bus8.Out_Data),  32'd0);
        chk("rst_out_sop",   32'(bus8.Out_Sop),   32'd0);
        chk("rst_locked",    32'(bus8.Locked),    32'd0);
        chk("rst_in_ready",  32'(bus8.In_Ready),  32'd1);

        // Known keystream, seed all-ones, zeros in, full throughput
        beat8(8'h00, 8'h00, 1'b1);
        chk("seq_b0", 32'(bus8.Out_Data), 32'h70);
        chk("seq_b0_sop", 32'(bus8.Out_Sop), 32'd1);
        chk("seq_b0_valid", 32'(bus8.Out_Valid), 32'd1);
        chk("seq_b0_locked", 32'(bus8.Locked), 32'd1);
        beat8(8'h00, 8'h00, 1'b0);
        chk("seq_b1", 32'(bus8.Out_Data), 32'h4F);
        chk("seq_b1_sop", 32'(bus8.Out_Sop), 32'd0);
        beat8(8'h00, 8'h00, 1'b0);
        chk("seq_b2", 32'(bus8.Out_Data), 32'h93);
        beat8(8'h00, 8'h00, 1'b0);
        chk("seq_b3", 32'(bus8.Out_Data), 32'h40);
        beat8(8'h00, 8'h00, 1'b0);
        chk("seq_b4", 32'(bus8.Out_Data), 32'h64);

        // SOP without valid is ignored; stream continues unseeded
        bus8.In_Sop = 1'b1;
        @(posedge clk);
        #1;
        bus8.In_Sop = 1'b0;
        chk("idle_valid_drop", 32'(bus8.Out_Valid), 32'd0);
        beat8(8'h00, 8'h00, 1'b0);
        chk("sop_novalid_b5", 32'(bus8.Out_Data), 32'h74);

        // Data XOR, other seeds, zero-seed substitution
        beat8(8'hFF, 8'h00, 1'b1);
        chk("data_ff", 32'(bus8.Out_Data), 32'h8F);
        bus8.Seed = 7'h01;
        beat8(8'h00, 8'h00, 1'b1);
        chk("seed01", 32'(bus8.Out_Data), 32'hC8);
        bus8.Seed = 7'h00;
        beat8(8'h00, 8'h00, 1'b1);
        chk("seed00", 32'(bus8.Out_Data), 32'h70);

        // Backpressure: output holds, input stalls, LFSR holds
        bus8.Out_Ready = 1'b0;
        bus8.In_Data   = 8'h00;
        bus8.In_Valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("stall_data",  32'(bus8.Out_Data),  32'h70);
            chk("stall_valid", 32'(bus8.Out_Valid), 32'd1);
            chk("stall_ready", 32'(bus8.In_Ready),  32'd0);
        end
        bus8.Out_Ready = 1'b1;
        @(posedge clk);
        #1;
        bus8.In_Valid = 1'b0;
        chk("stall_release", 32'(bus8.Out_Data), 32'h4F);
        beat8(8'h00, 8'h00, 1'b0);
        chk("stall_next", 32'(bus8.Out_Data), 32'h93);

        // Tail mask zeroes bits 0..5 but LFSR still advances
        bus8.Seed = 7'h7F;
        beat8(8'h00, 8'h00, 1'b1);
        chk("tail_b0", 32'(bus8.Out_Data), 32'h70);
        beat8(8'h00, 8'h3F, 1'b0);
        chk("tail_b1", 32'(bus8.Out_Data), 32'h40);
        beat8(8'h00, 8'h00, 1'b0);
        chk("tail_b2", 32'(bus8.Out_Data), 32'h93);

        // Seed recovery, W=8: lock within the first beat, then plain descramble
        bus8.Mode = 1'b1;
        beat8(8'h70, 8'h00, 1'b1);
        bus8.Mode = 1'b0;
        chk("rec_b0", 32'(bus8.Out_Data), 32'h00);
        chk("rec_b0_locked", 32'(bus8.Locked), 32'd1);
        beat8(8'h73, 8'h00, 1'b0);
        chk("rec_b1", 32'(bus8.Out_Data), 32'h3C);
        beat8(8'h36, 8'h00, 1'b0);
        chk("rec_b2", 32'(bus8.Out_Data), 32'hA5);

        // Reset while a beat is held, then a non-SOP beat uses the all-ones state
        beat8(8'h00, 8'h00, 1'b1);
        chk("prerst_b0", 32'(bus8.Out_Data), 32'h70);
        bus8.Out_Ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus8.Out_Ready = 1'b1;
        chk("midrst_valid",  32'(bus8.Out_Valid), 32'd0);
        chk("midrst_locked", 32'(bus8.Locked),    32'd0);
        beat8(8'h00, 8'h00, 1'b0);
        chk("postrst_b0", 32'(bus8.Out_Data), 32'h70);
        chk("postrst_sop", 32'(bus8.Out_Sop), 32'd0);

        // W=1 keystream, bit 0 first
        for (int i = 0; i < 16; i++) begin
            bit1(1'b0, (i == 0));
            chk($sformatf("w1_seq_%0d", i), 32'(bus1.Out_Data), 32'(ks[i]));
        end

        // W=1 seed recovery: Locked rises exactly on bit 6
        bus1.Mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bit1(ks[i], (i == 0));
            chk($sformatf("w1_rec_out_%0d", i), 32'(bus1.Out_Data), 32'd0);
            chk($sformatf("w1_rec_lock_%0d", i), 32'(bus1.Locked), (i >= 6) ? 32'd1 : 32'd0);
        end
        bus1.Mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
